// File: rtl/axim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axim_pkg                                                        |
// | Brief  : Shared types, AXI response codes and helpers for the AXI master |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package axim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axim_xfer_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axim_xfer_cnt                                                   |
// | Brief  : Loadable down-counter with a zero (done) flag; load wins over   |
// |          decrement, and the count never wraps below zero.                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module axim_xfer_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/axim_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : axim_wr_ctrl                                                    |
// | Brief  : AXI4 burst write master fed by a valid/ready store stream.      |
// |          Define AXIM_WR_ERR_CHK_EN for the sticky bresp error flag.      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module axim_wr_ctrl
  import axim_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 16,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ctrl_start,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  output logic                            ctrl_err,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_tdata,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic [1:0]                      m_axi_bresp
);

  localparam int BPB        = bytes_per_beat(C_M_AXI_DATA_WIDTH);
  localparam int BPB_LOG2   = $clog2(BPB);
  localparam int BLEN_LOG2  = $clog2(C_BURST_LEN);
  localparam int ALIGN_LOG2 = BPB_LOG2 + BLEN_LOG2;
  localparam int BEAT_W     = C_XFER_SIZE_WIDTH;
  localparam int BLEN_W     = BLEN_LOG2 + 1;
  localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * BPB);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((C_M_AXI_ADDR_WIDTH'(1) << ALIGN_LOG2) - C_M_AXI_ADDR_WIDTH'(1));

  state_t                          state_d, state_q;
  logic                            awvalid_d, awvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, awaddr_q, next_addr_d, next_addr_q;
  logic [7:0]                      awlen_d, awlen_q, last_awlen_d, last_awlen_q;
  logic [BEAT_W-1:0]               w_rem_d, w_rem_q;
  logic [OUT_W-1:0]                out_d, out_q, ahead_d, ahead_q;

  logic [BEAT_W:0]   size_ext, burst_ext;
  logic [BEAT_W-1:0] beats, bursts, w_rem_m1;
  logic [BLEN_W-1:0] first_wlen, next_wlen, w_load_val, w_beat_cnt;
  logic [BEAT_W-1:0] aw_rem_cnt, b_rem_cnt;
  logic              aw_rem_done, w_beat_done, b_rem_done;
  logic              start_acc, aw_hs, w_hs, w_last_hs, b_hs, aw_issue, w_allowed, w_load;

  assign start_acc = (state_q == IDLE) && ctrl_start;
  assign aw_hs     = awvalid_q && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign w_last_hs = w_hs && m_axi_wlast;
  assign b_hs      = m_axi_bvalid && m_axi_bready;

  // Beat and burst counts are both ceilings; one spare bit keeps the adds from overflowing.
  assign size_ext   = {1'b0, ctrl_xfer_size_in_bytes} + (BEAT_W+1)'(BPB - 1);
  assign beats      = BEAT_W'(size_ext >> BPB_LOG2);
  assign burst_ext  = {1'b0, beats} + (BEAT_W+1)'(C_BURST_LEN - 1);
  assign bursts     = BEAT_W'(burst_ext >> BLEN_LOG2);
  assign first_wlen = (beats >= BEAT_W'(C_BURST_LEN)) ? BLEN_W'(C_BURST_LEN) : BLEN_W'(beats);
  assign w_rem_m1   = w_rem_q - 1'b1;
  assign next_wlen  = (w_rem_m1 >= BEAT_W'(C_BURST_LEN)) ? BLEN_W'(C_BURST_LEN) : BLEN_W'(w_rem_m1);

  assign aw_issue  = (state_q == RUN) && !awvalid_q && !aw_rem_done &&
                     (out_q != OUT_W'(C_MAX_OUTSTANDING));
  // W of a burst may only flow once its AW has been accepted (ahead_q counts those bursts).
  assign w_allowed = (state_q == RUN) && !w_beat_done && (ahead_q != '0);
  assign w_load    = start_acc || (w_last_hs && (w_rem_q > BEAT_W'(1)));
  assign w_load_val = start_acc ? first_wlen : next_wlen;

  axim_xfer_cnt #(.WIDTH(BEAT_W)) u_aw_cnt (
    .clk(clk), .rst(rst), .load(start_acc), .load_val(bursts), .dec(aw_hs),
    .count(aw_rem_cnt), .done(aw_rem_done)
  );

  axim_xfer_cnt #(.WIDTH(BLEN_W)) u_w_cnt (
    .clk(clk), .rst(rst), .load(w_load), .load_val(w_load_val), .dec(w_hs),
    .count(w_beat_cnt), .done(w_beat_done)
  );

  axim_xfer_cnt #(.WIDTH(BEAT_W)) u_b_cnt (
    .clk(clk), .rst(rst), .load(start_acc), .load_val(bursts), .dec(b_hs),
    .count(b_rem_cnt), .done(b_rem_done)
  );

  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    next_addr_d  = next_addr_q;
    last_awlen_d = last_awlen_q;
    w_rem_d      = w_rem_q;
    out_d        = out_q;
    ahead_d      = ahead_q;

    case (state_q)
      IDLE: if (start_acc) state_d = (beats == '0) ? DONE : RUN;
      RUN:  if (b_hs && (b_rem_cnt == BEAT_W'(1))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_acc) begin
      next_addr_d  = ctrl_addr_offset & ALIGN_MASK;
      last_awlen_d = 8'((beats - 1'b1) & BEAT_W'(C_BURST_LEN - 1));
      w_rem_d      = beats;
    end

    if (aw_issue) begin
      awvalid_d = 1'b1;
      awaddr_d  = next_addr_q;
      awlen_d   = (aw_rem_cnt == BEAT_W'(1)) ? last_awlen_q : 8'(C_BURST_LEN - 1);
    end else if (aw_hs) begin
      awvalid_d   = 1'b0;
      next_addr_d = next_addr_q + BURST_BYTES;
    end

    if (w_hs) w_rem_d = w_rem_m1;

    if (aw_hs && !b_hs)      out_d = out_q + 1'b1;
    else if (!aw_hs && b_hs) out_d = out_q - 1'b1;

    if (aw_hs && !w_last_hs)      ahead_d = ahead_q + 1'b1;
    else if (!aw_hs && w_last_hs) ahead_d = ahead_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      next_addr_q  <= '0;
      last_awlen_q <= '0;
      w_rem_q      <= '0;
      out_q        <= '0;
      ahead_q      <= '0;
    end else begin
      state_q      <= state_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      next_addr_q  <= next_addr_d;
      last_awlen_q <= last_awlen_d;
      w_rem_q      <= w_rem_d;
      out_q        <= out_d;
      ahead_q      <= ahead_d;
    end
  end

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_wvalid  = s_tvalid && w_allowed;
  assign s_tready      = m_axi_wready && w_allowed;
  assign m_axi_wdata   = s_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_allowed && (w_beat_cnt == BLEN_W'(1));
  assign m_axi_bready  = (state_q == RUN) && !b_rem_done;
  assign ctrl_done     = (state_q == DONE);

`ifdef AXIM_WR_ERR_CHK_EN
  logic err_d, err_q;

  always_comb begin
    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (b_hs && (m_axi_bresp != RESP_OKAY)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign ctrl_err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
  assign ctrl_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axim_wr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_axim_wr_ctrl                                                 |
// | Brief  : Randomized self-checking bench for axim_wr_ctrl with a          |
// |          transfer-level reference model and a simple AXI slave.          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_axim_wr_ctrl;

  localparam int BL   = 16;
  localparam int MAXO = 4;
`ifdef AXIM_WR_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_start, ctrl_done, ctrl_err;
  logic [31:0] ctrl_addr_offset, ctrl_xfer_size_in_bytes;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;

  int n_checks = 0;
  int n_fail   = 0;
  int p_awr, p_wr, p_tv, p_bv;
  logic       prev_err;
  logic [1:0] resp_tbl [0:63];

  always #5 clk = ~clk;

  axim_wr_ctrl dut (
    .clk(clk), .rst(rst),
    .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_err(ctrl_err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  function automatic bit chance(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [51:0] out_vec();
    return {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_tready,
            ctrl_done, ctrl_err, m_axi_awaddr, m_axi_awlen, 5'd0};
  endfunction

  task automatic set_knobs(input int awr, input int wr, input int tv, input int bv);
    p_awr = awr; p_wr = wr; p_tv = tv; p_bv = bv;
  endtask

  // One complete transfer against the expected beat/burst plan of (base, size).
  task automatic run_xfer(input logic [31:0] base, input int size, input bit spur,
                          input int b_hold, input int abort_beat);
    int beats, bursts, n_aw, n_w, n_b, n_done, done_cyc, last_b_cyc, cyc, post;
    int bpend[$];
    logic [31:0] abase, cur, exp_addr;
    logic [7:0]  exp_len;
    bit fin, b_clr, err_acc, exp_wlast, aborted;
    beats = (size + 3) / 4;
    bursts = (beats + BL - 1) / BL;
    abase = base & ~(32'(BL * 4 - 1));
    n_aw = 0; n_w = 0; n_b = 0; n_done = 0; done_cyc = -1; last_b_cyc = -1;
    cyc = 0; post = 0; fin = 0; b_clr = 0; err_acc = 0; aborted = 0;
    cur = $urandom;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    while (!fin) begin
      @(negedge clk);
      if (b_clr) begin m_axi_bvalid = 1'b0; b_clr = 1'b0; end
      ctrl_start = (cyc == 0) || (spur && cyc == 6);
      ctrl_addr_offset = (cyc == 0) ? base : $urandom;
      ctrl_xfer_size_in_bytes = (cyc == 0) ? 32'(size) : $urandom_range(64, 4000);
      m_axi_awready = chance(p_awr);
      m_axi_wready  = chance(p_wr);
      s_tvalid      = chance(p_tv);
      s_tdata       = cur;
      if (!m_axi_bvalid && bpend.size() > 0 && cyc >= b_hold && chance(p_bv)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp_tbl[bpend[0]];
      end
      #1;
      if (cyc == 0) begin
        n_checks++;
        if (s_tready !== 1'b0 || ctrl_err !== prev_err) begin
          n_fail++;
          $display("FAIL idle_state: s_tready=%b ctrl_err=%b, expected 0 and %b", s_tready, ctrl_err, prev_err);
        end
      end
      if (cyc == 1) begin
        n_checks++;
        if (ctrl_err !== 1'b0) begin
          n_fail++; $display("FAIL err_clear_on_start: ctrl_err=%b, expected 0", ctrl_err);
        end
      end
      n_checks++;
      if ((m_axi_wvalid && m_axi_wready) !== (s_tvalid && s_tready)) begin
        n_fail++;
        $display("FAIL w_stream_hs cyc%0d: w_hs=%b s_hs=%b, expected equal", cyc,
                 m_axi_wvalid && m_axi_wready, s_tvalid && s_tready);
      end
      if (s_tvalid && s_tready) begin
        exp_wlast = (n_w % BL == BL - 1) || (n_w == beats - 1);
        n_checks++;
        if (n_w >= beats || (n_w / BL) >= n_aw ||
            {m_axi_wdata, m_axi_wlast, m_axi_wstrb} !== {cur, exp_wlast, 4'hF}) begin
          n_fail++;
          $display("FAIL w_beat%0d: data=%h last=%b strb=%h aw_done=%0d, expected data=%h last=%b strb=f beats=%0d",
                   n_w, m_axi_wdata, m_axi_wlast, m_axi_wstrb, n_aw, cur, exp_wlast, beats);
        end
        if (exp_wlast) bpend.push_back(n_w / BL);
        n_w++;
        cur = $urandom;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        exp_addr = abase + 32'(n_aw) * 32'(BL * 4);
        exp_len  = (n_aw == bursts - 1) ? 8'((beats - 1) % BL) : 8'(BL - 1);
        n_checks++;
        if (n_aw >= bursts || (n_aw - n_b) >= MAXO ||
            {m_axi_awaddr, m_axi_awlen} !== {exp_addr, exp_len}) begin
          n_fail++;
          $display("FAIL aw_burst%0d: addr=%h len=%0d outstanding=%0d, expected addr=%h len=%0d of %0d bursts",
                   n_aw, m_axi_awaddr, m_axi_awlen, n_aw - n_b, exp_addr, exp_len, bursts);
        end
        n_aw++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        n_checks++;
        if (bpend.size() == 0) begin
          n_fail++; $display("FAIL b_unexpected: bready accepted a response with no finished burst");
        end else begin
          if (m_axi_bresp != 2'b00) err_acc = 1'b1;
          void'(bpend.pop_front());
        end
        n_b++; b_clr = 1'b1; last_b_cyc = cyc;
      end
      if (b_hold > 0 && cyc == b_hold - 1) begin
        n_checks++;
        if (n_aw !== MAXO || m_axi_awvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL outstanding_limit: aw=%0d awvalid=%b, expected %0d and 0", n_aw, m_axi_awvalid, MAXO);
        end
      end
      if (n_done > 0) begin
        n_checks++;
        if (s_tready !== 1'b0) begin
          n_fail++; $display("FAIL tready_after_run: s_tready=%b, expected 0", s_tready);
        end
      end
      if (ctrl_done) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc = cyc;
          n_checks++;
          if (n_aw != bursts || n_w != beats || n_b != bursts ||
              done_cyc != ((size == 0) ? 1 : last_b_cyc + 1) || ctrl_err !== (ERR_EN && err_acc)) begin
            n_fail++;
            $display("FAIL done_state: aw=%0d w=%0d b=%0d done_cyc=%0d err=%b, expected %0d %0d %0d %0d %b",
                     n_aw, n_w, n_b, done_cyc, ctrl_err, bursts, beats, bursts,
                     (size == 0) ? 1 : last_b_cyc + 1, ERR_EN && err_acc);
          end
        end
      end
      if (n_done > 0) begin
        if (post == 2) fin = 1'b1;
        post++;
      end
      if (abort_beat >= 0 && n_w == abort_beat && !fin) begin
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== 52'd0) begin
          n_fail++; $display("FAIL async_reset_outputs: got %h, expected all zero", out_vec());
        end
        m_axi_bvalid = 1'b0; s_tvalid = 1'b0; ctrl_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        aborted = 1'b1; fin = 1'b1;
      end
      cyc++;
      if (cyc > 6000 && !fin) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: no ctrl_done after %0d cycles (aw=%0d w=%0d b=%0d)", cyc, n_aw, n_w, n_b);
        fin = 1'b1;
      end
    end
    ctrl_start = 1'b0; m_axi_bvalid = 1'b0;
    if (aborted) begin
      prev_err = 1'b0;
    end else begin
      n_checks++;
      if (n_done != 1) begin
        n_fail++; $display("FAIL done_pulse_count: %0d pulses, expected 1", n_done);
      end
      prev_err = ERR_EN && err_acc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (out_vec() !== 52'd0) begin
      n_fail++; $display("FAIL reset_state: got %h, expected all zero", out_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    prev_err = 1'b0;
  endtask

  task automatic test_full_bursts();
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_1000, 256, 1'b0, 0, -1);
  endtask

  task automatic test_partial_burst();
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_2000, 100, 1'b0, 0, -1);
    run_xfer(32'h0000_2417, 4, 1'b0, 0, -1);
  endtask

  task automatic test_outstanding();
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_3000, 512, 1'b0, 200, -1);
  endtask

  task automatic test_zero_size();
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_5000, 0, 1'b0, 0, -1);
  endtask

  task automatic test_ignored_start();
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_6000, 256, 1'b1, 0, -1);
  endtask

  task automatic test_bresp_error();
    set_knobs(100, 100, 100, 100);
    resp_tbl[2] = 2'b10;
    run_xfer(32'h0000_7000, 256, 1'b0, 0, -1);
    resp_tbl[2] = 2'b00;
    run_xfer(32'h0000_7400, 128, 1'b0, 0, -1);
  endtask

  task automatic test_reset_mid_transfer();
    set_knobs(60, 70, 70, 80);
    run_xfer(32'h0000_8000, 256, 1'b0, 0, 20);
    set_knobs(100, 100, 100, 100);
    run_xfer(32'h0000_9000, 64, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      for (int i = 0; i < 64; i++) resp_tbl[i] = chance(10) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_xfer($urandom, int'($urandom_range(0, 700)), 1'b0, 0, -1);
    end
  endtask

  initial begin
    ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; prev_err = 1'b0;
    for (int i = 0; i < 64; i++) resp_tbl[i] = 2'b00;
    test_reset();
    test_full_bursts();
    test_partial_burst();
    test_outstanding();
    test_zero_size();
    test_ignored_start();
    test_bresp_error();
    test_reset_mid_transfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axim_wr_ctrl.md
AXIM_WR_CTRL -- requirements
Module: axim_wr_ctrl

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI/stream data width (32, 64 or 128).
REQ-003 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, byte-count width.
REQ-004 SHALL have parameter C_BURST_LEN, default 16, beats per full burst (power of 2, 1..256).
REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 4, maximum bursts awaiting B response.
REQ-006 SHALL have port clk, input, 1, the only clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports ctrl_start (input, 1, start pulse) and ctrl_done (output, 1, completion pulse).
REQ-009 SHALL have ports ctrl_addr_offset (input, C_M_AXI_ADDR_WIDTH, base byte address) and ctrl_xfer_size_in_bytes (input, C_XFER_SIZE_WIDTH, byte count).
REQ-010 SHALL have port ctrl_err, output, 1, sticky write-error flag.
REQ-011 SHALL have ports s_tvalid (input, 1), s_tready (output, 1) and s_tdata (input, C_M_AXI_DATA_WIDTH), the store-data stream from the buffer array's rd_* port.
REQ-012 SHALL have AXI4 AW ports: m_axi_awvalid (out, 1), m_axi_awready (in, 1), m_axi_awaddr (out, ADDR), m_axi_awlen (out, 8).
REQ-013 SHALL have AXI4 W ports: m_axi_wvalid (out, 1), m_axi_wready (in, 1), m_axi_wdata (out, DATA), m_axi_wstrb (out, DATA/8), m_axi_wlast (out, 1).
REQ-014 SHALL have AXI4 B ports: m_axi_bvalid (in, 1), m_axi_bready (out, 1), m_axi_bresp (in, 2).

Function
REQ-015 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on ctrl_start; RUN->DONE once the last B handshake is accepted; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL register ctrl_addr_offset and ctrl_xfer_size_in_bytes on ctrl_start in IDLE, and SHALL ignore ctrl_start outside IDLE.
REQ-017 SHALL compute the total beat count as ceil(size / (DATA/8)), and the burst count as ceil(beats / C_BURST_LEN).
REQ-018 SHALL force the low log2(C_BURST_LEN*DATA/8) bits of the base address to zero, so no burst crosses a 4 KB boundary.
REQ-019 SHALL set m_axi_awlen = C_BURST_LEN-1 for full bursts, and (remaining beats - 1) for the final partial burst.
REQ-020 SHALL drive m_axi_awaddr = base + k*C_BURST_LEN*DATA/8 for burst k.
REQ-021 SHALL keep awvalid asserted with awaddr/awlen stable until awready is sampled high.
REQ-022 SHALL keep an outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle; AW SHALL NOT be issued while the counter equals C_MAX_OUTSTANDING.
REQ-023 SHALL send W beats of burst k only after the AW of burst k has completed its handshake.
REQ-024 SHALL drive wvalid = s_tvalid & w_allowed, s_tready = m_axi_wready & w_allowed and wdata = s_tdata, with zero added latency.
REQ-025 SHALL drive wstrb all ones, and SHALL assert wlast on the final beat of each burst.
REQ-026 SHALL hold bready high in RUN and low otherwise.
REQ-027 SHALL pulse ctrl_done high for exactly one cycle, in the DONE state.
REQ-028 SHALL, for a size of 0, go IDLE->DONE with no AXI traffic, pulsing ctrl_done on the cycle after ctrl_start.
REQ-029 SHALL hold s_tready low in IDLE and DONE, so no stream data is consumed outside a transfer.

Reset
REQ-030 SHALL, while rst is low, immediately force: state IDLE; all counters 0; awvalid, wvalid, wlast, bready, s_tready, ctrl_done and ctrl_err 0; awaddr and awlen 0.
REQ-031 SHALL, when reset is asserted mid-transfer, abandon the transfer without completing in-flight bursts; after reset release the block SHALL accept a new ctrl_start.

Configuration
REQ-032 SHALL, with macro AXIM_WR_ERR_CHK_EN defined, set ctrl_err on any B handshake with bresp != 2'b00, and clear it on an accepted ctrl_start.
REQ-033 SHALL, without AXIM_WR_ERR_CHK_EN, tie ctrl_err to 0 and ignore bresp.

Structure
REQ-034 SHALL place in shared package axim_pkg: the state enum (IDLE/RUN/DONE), the AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), and the bytes-per-beat function.
REQ-035 SHALL instantiate sub-module axim_xfer_cnt (loadable down-counter with done flag) three times: AW bursts remaining, W beats-in-burst, and B responses remaining.

Verification
REQ-036 SHALL cover: base 0x1000, size 256 B, DATA 32, ready always 1 -> 4 AW with awlen 15 at 0x1000/0x1040/0x1080/0x10C0, 64 W beats, wlast on beats 16/32/48/64, one ctrl_done pulse.
REQ-037 SHALL cover: size 100 B -> 25 beats, AW awlen 15 then 8, wlast on beats 16 and 25.
REQ-038 SHALL cover: awready high, bvalid held low -> exactly 4 AW handshakes then awvalid stays low; releasing B resumes AW issue.
REQ-039 SHALL cover: size 0 -> no awvalid, ctrl_done exactly 1 cycle after ctrl_start.
REQ-040 SHALL cover: with AXIM_WR_ERR_CHK_EN defined and bresp=2 on burst 2 -> ctrl_err=1 through ctrl_done, cleared by the next ctrl_start.
REQ-041 SHALL cover: random s_tvalid/wready/awready toggling plus rst pulled low at beat 20 -> all outputs 0 asynchronously, and a subsequent 64 B transfer completes correctly.
